// File: rtl/pb_sequence_detector_if.sv
// Push-button detector signal bundle: raw buttons in, debounced pulses and
// sequence status out. The detector sits on the slave side.
interface pb_sequence_detector_if #(
  parameter int NUM_PB      = 4,
  parameter int PRESS_COUNT = 3
);
  localparam int IW = (NUM_PB > 2) ? $clog2(NUM_PB) : 1;
  localparam int CW = $clog2(PRESS_COUNT + 1);

  logic [NUM_PB-1:0] PUSH_BUTTON_N_I;
  logic [NUM_PB-1:0] pb_pressed;
  logic [IW-1:0]     active_button;
  logic [CW-1:0]     press_count;
  logic              detect_valid;
  logic              detect_pulse;
  logic              timeout_pulse;

  modport master (
    output PUSH_BUTTON_N_I,
    input  pb_pressed, active_button, press_count,
    input  detect_valid, detect_pulse, timeout_pulse
  );

  modport slave (
    input  PUSH_BUTTON_N_I,
    output pb_pressed, active_button, press_count,
    output detect_valid, detect_pulse, timeout_pulse
  );
endinterface

// File: rtl/pb_sequence_detector.sv
// Debounces NUM_PB active-low buttons on a divided tick and detects
// PRESS_COUNT consecutive presses of the same counting button.
module pb_debounce #(
  parameter int DEPTH = 10
) (
  input  logic CLOCK_50_I,
  input  logic resetn,
  input  logic tick,
  input  logic btn_n,
  output logic pressed
);
  logic [DEPTH-1:0] sr;
  logic             sample;
  logic             status, status_buf;

  assign sample = ~btn_n;

  // status stays high until DEPTH consecutive released samples have been seen
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      sr         <= '0;
      status     <= 1'b0;
      status_buf <= 1'b0;
    end else begin
      if (tick) sr <= (sr << 1) | DEPTH'(sample);
      status     <= |sr;
      status_buf <= status;
    end
  end

  assign pressed = status & ~status_buf;
endmodule

module pb_sequence_detector #(
  parameter int              NUM_PB         = 4,
  parameter int              PRESS_COUNT    = 3,
  parameter int              DEBOUNCE_DEPTH = 10,
  parameter int              DIV_COUNT      = 49999,
  parameter int              TIMEOUT_TICKS  = 2000,
  parameter logic [NUM_PB-1:0] CLEAR_MASK   = 4'b1100
) (
  input  logic                   CLOCK_50_I,
  input  logic                   resetn,
  pb_sequence_detector_if.slave  pb
);
  localparam int IW = (NUM_PB > 2) ? $clog2(NUM_PB) : 1;
  localparam int CW = $clog2(PRESS_COUNT + 1);
  localparam int DW = (DIV_COUNT > 0) ? $clog2(DIV_COUNT + 1) : 1;
  localparam int TW = (TIMEOUT_TICKS > 2) ? $clog2(TIMEOUT_TICKS) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_TICKS > 0) ? TIMEOUT_TICKS - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DETECTED} state_t;

  logic [DW-1:0]     div_cnt;
  logic              tick;
  logic [NUM_PB-1:0] btn_n, pressed, cnt_edges;
  logic              clr, any_cnt;
  logic [IW-1:0]     sel;

  state_t            state, state_n;
  logic [CW-1:0]     press_count, count_n, count_inc;
  logic [IW-1:0]     active_button, act_n;
  logic [TW-1:0]     to_cnt, to_cnt_n;
  logic              detect_pulse, det_n;
  logic              timeout_pulse, to_pulse_n;

  assign tick = (div_cnt == DW'(DIV_COUNT));

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) div_cnt <= '0;
    else         div_cnt <= tick ? '0 : div_cnt + 1'b1;
  end

  assign btn_n = pb.PUSH_BUTTON_N_I;

  pb_debounce #(.DEPTH(DEBOUNCE_DEPTH)) u_db [NUM_PB-1:0] (
    .CLOCK_50_I (CLOCK_50_I),
    .resetn     (resetn),
    .tick       (tick),
    .btn_n      (btn_n),
    .pressed    (pressed)
  );

  // Clear buttons outrank counted ones; among counted edges the lowest index wins.
  always_comb begin
    clr       = |(pressed & CLEAR_MASK);
    cnt_edges = pressed & ~CLEAR_MASK;
    any_cnt   = |cnt_edges;
    sel       = '0;
    for (int i = NUM_PB - 1; i >= 0; i--)
      if (cnt_edges[i]) sel = IW'(i);
  end

  assign count_inc = press_count + CW'(1);

  always_comb begin
    state_n    = state;
    count_n    = press_count;
    act_n      = active_button;
    det_n      = 1'b0;
    to_pulse_n = 1'b0;
    to_cnt_n   = '0;
    if (clr) begin
      state_n = S_IDLE;
      count_n = '0;
      act_n   = '0;
    end else begin
      case (state)
        S_IDLE: if (any_cnt) begin
          state_n = S_COUNT;
          act_n   = sel;
          count_n = CW'(1);
        end
        S_COUNT: if (any_cnt) begin
          if (sel == active_button) begin
            count_n = count_inc;
            if (count_inc == CW'(PRESS_COUNT)) begin
              state_n = S_DETECTED;
              det_n   = 1'b1;
            end
          end else begin
            act_n   = sel;
            count_n = CW'(1);
          end
        end else begin
          // an edge in the expiry cycle takes the branch above, so it wins
          to_cnt_n = to_cnt;
          if (TIMEOUT_TICKS != 0 && tick) begin
            if (to_cnt == TO_LAST) begin
              state_n    = S_IDLE;
              to_pulse_n = 1'b1;
              count_n    = '0;
              act_n      = '0;
              to_cnt_n   = '0;
            end else begin
              to_cnt_n = to_cnt + 1'b1;
            end
          end
        end
        S_DETECTED: if (any_cnt && sel != active_button) begin
          state_n = S_COUNT;
          act_n   = sel;
          count_n = CW'(1);
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state         <= S_IDLE;
      press_count   <= '0;
      active_button <= '0;
      to_cnt        <= '0;
      detect_pulse  <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      state         <= state_n;
      press_count   <= count_n;
      active_button <= act_n;
      to_cnt        <= to_cnt_n;
      detect_pulse  <= det_n;
      timeout_pulse <= to_pulse_n;
    end
  end

  assign pb.pb_pressed    = pressed;
  assign pb.active_button = active_button;
  assign pb.press_count   = press_count;
  assign pb.detect_valid  = (state == S_DETECTED);
  assign pb.detect_pulse  = detect_pulse;
  assign pb.timeout_pulse = timeout_pulse;
endmodule
